// File: rtl/and_gate_vector_engine.sv
// and_gate_vector_engine: sweeps and_gate inputs, samples y after a settle window and tallies pass/fail
module and_gate_vector_engine #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             fail_seen,
    output logic [1:0]       fail_vec
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
    localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = NUM_PASSES > 1 ? $clog2(NUM_PASSES) : 1;
    localparam int SL = SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0;
    localparam int PL = NUM_PASSES - 1;
    localparam logic [SW-1:0] SLAST = SL[SW-1:0];
    localparam logic [PW-1:0] PLAST = PL[PW-1:0];

    logic [2:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d, ab_q, ab_d, fvec_q, fvec_d;
    logic [PW-1:0]    pc_q, pc_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d;
    logic             fseen_q, fseen_d;

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = state_q == DRIVE || state_q == SETTLE || state_q == SAMPLE;
    assign done      = state_q == DONE;
    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign fail_seen = fseen_q;
    assign fail_vec  = fvec_q;

    // Sequencer next state: vector stepping, settle timing and saturating tallies
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pc_d    = pc_q;
        scnt_d  = scnt_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        fseen_d = fseen_q;
        fvec_d  = fvec_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = DRIVE;
                idx_d   = '0;
                pc_d    = '0;
                pass_d  = '0;
                fail_d  = '0;
                fseen_d = 1'b0;
                fvec_d  = '0;
            end
            DRIVE: begin
                state_d = SETTLE_CYCLES > 0 ? SETTLE : SAMPLE;
                scnt_d  = '0;
            end
            SETTLE: begin
                scnt_d  = scnt_q + 1'b1;
                state_d = scnt_q == SLAST ? SAMPLE : SETTLE;
            end
            SAMPLE: begin
                if (y == (ab_q[1] & ab_q[0])) begin
                    pass_d = pass_q + CNT_W'(~&pass_q);
                end else begin
                    fail_d  = fail_q + CNT_W'(~&fail_q);
                    fseen_d = 1'b1;
                    fvec_d  = fseen_q ? fvec_q : ab_q;
                end
                if (idx_q == 2'd3 && pc_q == PLAST) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 2'd1;
                    pc_d    = idx_q == 2'd3 ? pc_q + 1'b1 : pc_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ab_d = (state_d == DRIVE || state_d == SETTLE || state_d == SAMPLE) ? idx_d : 2'b00;
    end

    // State and output registers; reset aborts any sweep at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pc_q    <= '0;
            scnt_q  <= '0;
            ab_q    <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            fseen_q <= 1'b0;
            fvec_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            scnt_q  <= scnt_d;
            ab_q    <= ab_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            fseen_q <= fseen_d;
            fvec_q  <= fvec_d;
        end
    end
endmodule

// File: tb/tb_and_gate_vector_engine.sv
// tb_and_gate_vector_engine: directed table-driven check of the and_gate vector engine
module tb_and_gate_vector_engine;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, start2 = 1'b0;
    logic       y, a, b, busy, done, fail_seen;
    logic [7:0] pass_cnt, fail_cnt;
    logic [1:0] fail_vec;
    logic       y2, a2, b2, busy2, done2, fail_seen2;
    logic [7:0] pass_cnt2, fail_cnt2;
    logic [1:0] fail_vec2;
    int         ymode = 0;
    int         cmp = 0, bad = 0;

    typedef struct {
        string name;
        int    ymode;
        int    ep;
        int    ef;
        int    es;
        int    ev;
    } vec_t;
    vec_t tbl[4];

    always #5 clk = ~clk;

    // and_gate model: 0 good, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
    always_comb begin
        y = ymode == 0 ? (a & b) : ymode == 1 ? 1'b0 : ymode == 2 ? 1'b1 : ~(a & b);
        y2 = a2 & b2;
    end

    and_gate_vector_engine u1 (
        .clk(clk), .rst(rst), .start(start), .y(y), .a(a), .b(b), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .fail_seen(fail_seen), .fail_vec(fail_vec)
    );

    and_gate_vector_engine #(.SETTLE_CYCLES(0), .NUM_PASSES(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .y(y2), .a(a2), .b(b2), .busy(busy2), .done(done2),
        .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .fail_seen(fail_seen2), .fail_vec(fail_vec2)
    );

    task automatic chk(input string n, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", n, act, exp);
        end
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_ab_busy_done"}, int'({a, b, busy, done}), 0);
        chk({n, "_cnts"}, int'({pass_cnt, fail_cnt}), 0);
        chk({n, "_fail"}, int'({fail_seen, fail_vec}), 0);
    endtask

    task automatic sweep(output int lat);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (k % 4 == 0 && k < 16) chk("busy_ab_step", int'({busy, a, b}), 4 + k / 4);
            @(negedge clk);
        end
        chk("latency", lat, 16);
        @(negedge clk);
        chk("done_one_cycle", int'({done, busy}), 0);
    endtask

    initial begin
        int lat, seen;
        tbl[0] = '{"good",     0, 4, 0, 0, 0};
        tbl[1] = '{"stuck0",   1, 3, 1, 1, 3};
        tbl[2] = '{"stuck1",   2, 1, 3, 1, 0};
        tbl[3] = '{"inverted", 3, 0, 4, 1, 0};
        repeat (2) @(negedge clk);
        chk_zero("reset");
        chk("reset_u2", int'({a2, b2, busy2, done2, pass_cnt2, fail_cnt2}), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ymode = tbl[i].ymode;
            sweep(lat);
            chk({tbl[i].name, "_pass"}, int'(pass_cnt), tbl[i].ep);
            chk({tbl[i].name, "_fail"}, int'(fail_cnt), tbl[i].ef);
            chk({tbl[i].name, "_seen"}, int'(fail_seen), tbl[i].es);
            chk({tbl[i].name, "_vec"}, int'(fail_vec), tbl[i].ev);
        end
        ymode = 3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_fail_before_rst", int'({fail_seen, fail_cnt}), 256 + 1);
        #2 rst = 1'b1;
        #1 chk_zero("async_rst");
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        ymode = 0;
        sweep(lat);
        chk("after_rst_cnts", int'({pass_cnt, fail_cnt}), 4 * 256);
        chk("after_rst_seen", int'({fail_seen, fail_vec}), 0);
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (done2) begin
                lat = k;
                break;
            end
            if (k % 2 == 0 && k < 16) chk("p2_busy_ab_step", int'({busy2, a2, b2}), 4 + (k / 2) % 4);
            @(negedge clk);
            start2 = k == 2;
        end
        start2 = 1'b0;
        chk("p2_latency", lat, 16);
        chk("p2_pass", int'(pass_cnt2), 8);
        chk("p2_fail", int'({fail_seen2, fail_cnt2}), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
